stack_ctrl: RTL and testbench

Request front-end for the LIFO stack memory. Accepts push/pop/flush commands over a valid/ready handshake and sequences them into the stack's single-cycle `en`/`rw`/`clear` controls. Tracks occupancy and returns one response per command with the popped data or an overflow/underflow error. Sits directly upstream of the stack; the stack's `data_out`, `full` and `empty` feed back into this block.

---
 rtl/stack_pkg.sv | 22 ++
 rtl/stack_ctrl_stats.sv | 35 +++
 rtl/stack_ctrl.sv | 152 +++++++++++++++
 tb/tb_stack_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack front-end: op encodings, FSM states, capacity.
package stack_pkg;

  localparam logic [1:0] OP_POP   = 2'b00;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_FLUSH = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_EXEC,
    ST_CAPT,
    ST_RESP
  } state_t;

  // One address slot is sacrificed so full and empty stay distinguishable.
  function automatic int stack_cap(input int h);
    return (1 << h) - 1;
  endfunction

endpackage

// File: rtl/stack_ctrl_stats.sv
// Statistics for stack_ctrl: saturating push/pop counters and occupancy high-water mark.
module stack_ctrl_stats #(
  parameter int H = 3
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        push_stb,
  input  logic        pop_stb,
  input  logic        flush_stb,
  input  logic [H:0]  count,
  output logic [H:0]  hwm,
  output logic [15:0] push_cnt,
  output logic [15:0] pop_cnt
);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      hwm      <= '0;
      push_cnt <= '0;
      pop_cnt  <= '0;
    end else if (flush_stb) begin
      hwm      <= '0;
      push_cnt <= '0;
      pop_cnt  <= '0;
    end else begin
      if (count > hwm)
        hwm <= count;
      if (push_stb && push_cnt != 16'hFFFF)
        push_cnt <= push_cnt + 16'd1;
      if (pop_stb && pop_cnt != 16'hFFFF)
        pop_cnt <= pop_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// Command front-end for the LIFO stack: one command in flight, error screening on count.
// Statistics outputs are live only when STACK_CTRL_STATS_EN is defined.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int W = 8,
  parameter int H = 3
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic [H:0]   count,
  output logic         ovf_sticky,
  output logic         udf_sticky,
  output logic         stk_en,
  output logic         stk_rw,
  output logic         stk_clear,
  output logic [W-1:0] stk_data_in,
  input  logic [W-1:0] stk_data_out,
  input  logic         stk_full,
  input  logic         stk_empty,
  output logic [H:0]   hwm,
  output logic [15:0]  push_cnt,
  output logic [15:0]  pop_cnt
);

  localparam logic [H:0] CAP = (H+1)'(stack_cap(H));

  state_t     state, state_n;
  logic [1:0] op_q;
  logic       ovf_hit, udf_hit, cmd_err;

  assign ovf_hit = (cmd_op == OP_PUSH) && (count == CAP);
  assign udf_hit = (cmd_op == OP_POP) && (count == '0);
  assign cmd_err = ovf_hit || udf_hit || (cmd_op == OP_RSVD);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= ST_INIT;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    stk_en    = 1'b0;
    stk_rw    = 1'b0;
    stk_clear = 1'b0;
    case (state)
      ST_INIT: begin
        stk_en    = 1'b1;
        stk_clear = 1'b1;
        state_n   = ST_IDLE;
      end
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          state_n = cmd_err ? ST_RESP : ST_EXEC;
      end
      ST_EXEC: begin
        stk_en    = 1'b1;
        stk_rw    = (op_q == OP_PUSH);
        stk_clear = (op_q == OP_FLUSH);
        state_n   = ST_CAPT;
      end
      ST_CAPT: state_n = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_n = ST_IDLE;
      end
      default: state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      op_q        <= OP_POP;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      count       <= '0;
      ovf_sticky  <= 1'b0;
      udf_sticky  <= 1'b0;
      stk_data_in <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cmd_valid) begin
          op_q     <= cmd_op;
          rsp_data <= '0;
          rsp_err  <= cmd_err;
          // Loaded at accept so the write data is already stable during EXEC.
          if (cmd_op == OP_PUSH && !cmd_err)
            stk_data_in <= cmd_data;
          if (ovf_hit) ovf_sticky <= 1'b1;
          if (udf_hit) udf_sticky <= 1'b1;
        end
        ST_EXEC: begin
          case (op_q)
            OP_PUSH: count <= count + 1'b1;
            OP_POP:  count <= count - 1'b1;
            OP_FLUSH: begin
              count      <= '0;
              ovf_sticky <= 1'b0;
              udf_sticky <= 1'b0;
            end
            default: ;
          endcase
        end
        ST_CAPT: if (op_q == OP_POP) rsp_data <= stk_data_out;
        default: ;
      endcase
    end
  end

`ifdef STACK_CTRL_STATS_EN
  logic push_stb, pop_stb, flush_stb;

  assign push_stb  = (state == ST_EXEC) && (op_q == OP_PUSH);
  assign pop_stb   = (state == ST_EXEC) && (op_q == OP_POP);
  assign flush_stb = (state == ST_EXEC) && (op_q == OP_FLUSH);

  stack_ctrl_stats #(.H(H)) u_stats (
    .clk       (clk),
    .clear     (clear),
    .push_stb  (push_stb),
    .pop_stb   (pop_stb),
    .flush_stb (flush_stb),
    .count     (count),
    .hwm       (hwm),
    .push_cnt  (push_cnt),
    .pop_cnt   (pop_cnt)
  );
`else
  assign hwm      = '0;
  assign push_cnt = '0;
  assign pop_cnt  = '0;
`endif

  // The stack's own flags must agree with our count whenever we are waiting for work.
  a_empty: assert property (@(posedge clk) disable iff (clear)
    (state == ST_IDLE) |-> (stk_empty == (count == '0)));
  a_full: assert property (@(posedge clk) disable iff (clear)
    (state == ST_IDLE) |-> (stk_full == (count == CAP)));

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed + randomized bench for stack_ctrl against a queue-based LIFO reference model.
module tb_stack_ctrl;
  import stack_pkg::*;

  localparam int W = 8;
  localparam int H = 3;
  localparam int CAP = 7;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic [H:0]   count;
  logic         ovf_sticky, udf_sticky;
  logic         stk_en, stk_rw, stk_clear;
  logic [W-1:0] stk_data_in;
  logic [W-1:0] stk_data_out = '0;
  logic         stk_full, stk_empty;
  logic [H:0]   hwm;
  logic [15:0]  push_cnt, pop_cnt;

  always #5 clk = ~clk;

  stack_ctrl #(.W(W), .H(H)) dut (
    .clk          (clk),
    .clear        (clear),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .count        (count),
    .ovf_sticky   (ovf_sticky),
    .udf_sticky   (udf_sticky),
    .stk_en       (stk_en),
    .stk_rw       (stk_rw),
    .stk_clear    (stk_clear),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_full     (stk_full),
    .stk_empty    (stk_empty),
    .hwm          (hwm),
    .push_cnt     (push_cnt),
    .pop_cnt      (pop_cnt)
  );

  // Stack memory environment; starts with stale contents that only a clear pulse removes.
  logic [W-1:0] mem [8];
  logic [3:0]   sp = 4'd5;
  assign stk_full  = (sp == 4'd7);
  assign stk_empty = (sp == 4'd0);

  always @(posedge clk) begin
    if (stk_en) begin
      if (stk_clear) sp <= 4'd0;
      else if (stk_rw) begin
        if (sp < 4'd8) begin
          mem[sp[2:0]] <= stk_data_in;
          sp <= sp + 4'd1;
        end
      end else if (sp != 4'd0) begin
        stk_data_out <= mem[sp[2:0] - 3'd1];
        sp <= sp - 4'd1;
      end
    end
  end

  int vec = 0;
  int miss = 0;

  int unsigned q[$];
  bit m_ovf, m_udf;
  int m_hwm, m_push, m_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_hwm = 0; m_push = 0; m_pop = 0;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, count, q.size());
    check({tag, ".ovf"}, ovf_sticky, m_ovf);
    check({tag, ".udf"}, udf_sticky, m_udf);
`ifdef STACK_CTRL_STATS_EN
    check({tag, ".hwm"}, hwm, m_hwm);
    check({tag, ".push_cnt"}, push_cnt, m_push);
    check({tag, ".pop_cnt"}, pop_cnt, m_pop);
`else
    check({tag, ".hwm"}, hwm, 0);
    check({tag, ".push_cnt"}, push_cnt, 0);
    check({tag, ".pop_cnt"}, pop_cnt, 0);
`endif
  endtask

  // Called and returns at a falling edge.
  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] d, input int stall);
    logic         exp_err;
    logic [W-1:0] exp_data;
    int           k, en_pulses;
    exp_err  = 1'b0;
    exp_data = '0;
    case (op)
      OP_PUSH:
        if (q.size() == CAP) begin exp_err = 1'b1; m_ovf = 1; end
        else begin
          q.push_back(d);
          if (m_push < 65535) m_push++;
          if (q.size() > m_hwm) m_hwm = q.size();
        end
      OP_POP:
        if (q.size() == 0) begin exp_err = 1'b1; m_udf = 1; end
        else begin
          exp_data = W'(q.pop_back());
          if (m_pop < 65535) m_pop++;
        end
      OP_FLUSH: model_reset();
      default: exp_err = 1'b1;
    endcase

    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    check("cmd_ready_wait", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_data = W'($urandom);
    k = 1;
    en_pulses = int'(stk_en);
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
      en_pulses += int'(stk_en);
    end
    check("rsp_latency", k, exp_err ? 1 : 3);
    check("stk_en_pulses", en_pulses, exp_err ? 0 : 1);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_data", rsp_data, exp_data);
    check("cmd_ready_busy", cmd_ready, 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall.rsp_valid", rsp_valid, 1);
      check("stall.rsp_data", rsp_data, exp_data);
      check("stall.cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post.rsp_valid", rsp_valid, 0);
    check("post.cmd_ready", cmd_ready, 1);
    check_status("post");
  endtask

  task automatic do_reset();
    clear = 1'b1;
    #1;
    check("rst.cmd_ready", cmd_ready, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_data", rsp_data, 0);
    check("rst.rsp_err", rsp_err, 0);
    check("rst.stk_en", stk_en, 1);
    check("rst.stk_clear", stk_clear, 1);
    check("rst.stk_rw", stk_rw, 0);
    check("rst.stk_data_in", stk_data_in, 0);
    model_reset();
    check_status("rst");
    repeat (2) @(negedge clk);
    clear = 1'b0;
    #1;
    check("init.stk_clear", stk_clear, 1);
    check("init.cmd_ready", cmd_ready, 0);
    @(negedge clk);
    check("idle.stk_clear", stk_clear, 0);
    check("idle.stk_en", stk_en, 0);
    check("idle.cmd_ready", cmd_ready, 1);
    check("idle.count", count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_rsp, clr_pulses, r;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 7; i++) do_cmd(OP_PUSH, W'(8'h11 + i), 0);
    do_cmd(OP_PUSH, 8'h99, 0);
    for (int i = 0; i < 7; i++) do_cmd(OP_POP, '0, 0);
    do_cmd(OP_POP, '0, 0);
    do_cmd(OP_RSVD, 8'h3C, 0);
    do_cmd(OP_FLUSH, '0, 0);
    do_cmd(OP_PUSH, 8'hA5, 0);
    do_cmd(OP_POP, '0, 5);

    // Reset landing in the EXEC cycle of a push.
    do_cmd(OP_PUSH, 8'h21, 0);
    do_cmd(OP_PUSH, 8'h22, 0);
    cmd_op = OP_PUSH; cmd_data = 8'h23; cmd_valid = 1'b1;
    r = 0;
    while (!cmd_ready && r < 20) begin @(negedge clk); r++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("midrst.in_exec", {stk_en, stk_rw, stk_clear}, 3'b110);
    clear = 1'b1;
    #1;
    check("midrst.count", count, 0);
    check("midrst.stk_clear", stk_clear, 1);
    @(negedge clk);
    clear = 1'b0;
    #1;
    seen_rsp = 0;
    clr_pulses = int'(stk_clear);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen_rsp += int'(rsp_valid);
      clr_pulses += int'(stk_clear);
    end
    check("midrst.no_rsp", seen_rsp, 0);
    check("midrst.clr_pulses", clr_pulses, 1);
    model_reset();
    check_status("midrst");

    for (int i = 0; i < 120; i++) begin
      logic [1:0] op;
      r = $urandom_range(0, 19);
      if (r < 9)       op = OP_PUSH;
      else if (r < 17) op = OP_POP;
      else if (r < 18) op = OP_FLUSH;
      else             op = OP_RSVD;
      do_cmd(op, W'($urandom), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
